uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_if.sv | 17 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, 8N1 frame constants and the
// clocks-per-bit calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Clocks per serial bit, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Received-byte stream: FIFO head, valid/ready pop handshake and occupancy.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [CW-1:0]        o_count;

    modport master (output o_data, output o_valid, output o_count, input i_ready);
    modport slave  (input o_data, input o_valid, input o_count, output i_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no fall-through; a push while full is accepted only
// together with a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO. Define UART_RX_FRAME_CHECK_EN to
// discard bytes with a low stop bit and flag them on o_frame_err.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rxd,
    input  logic           i_clr_err,
    output logic           o_overrun,
    output logic           o_frame_err,
    uart_rx_fifo_if.master rx
);
    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned TW  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam int unsigned IW  = $clog2(DATA_BITS);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    if (DIV < 4) begin : g_div_chk
        $fatal(1, "uart_rx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "uart_rx_fifo: FIFO_DEPTH must be a power of two in 2..64");
    end

    uart_state_t          state;
    logic [1:0]           sync;
    logic                 rxd_s;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 push;
    logic [DATA_BITS-1:0] push_data;
    logic                 overrun;
    logic                 expire;
    logic                 stop_hit;
    logic                 frame_bad;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic [CW-1:0]        count;

    assign rxd_s    = sync[1];
    assign expire   = (timer == '0);
    assign stop_hit = (state == STOP) && expire;

`ifdef UART_RX_FRAME_CHECK_EN
    logic frame_err;

    assign frame_bad = stop_hit && !rxd_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_err <= 1'b0;
        end else if (frame_bad) begin
            frame_err <= 1'b1;
        end else if (i_clr_err) begin
            frame_err <= 1'b0;
        end
    end

    assign o_frame_err = frame_err;
`else
    assign frame_bad   = 1'b0;
    assign o_frame_err = 1'b0;
`endif

    // Synchroniser, bit-timing FSM and the registered push strobe one cycle after the stop sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync      <= 2'b11;
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            sync <= {sync[0], i_rxd};
            push <= stop_hit && !frame_bad;
            if (stop_hit) begin
                push_data <= shift;
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        timer <= TW'(DIV / 2 - 1);
                    end
                end
                START: begin
                    if (expire) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            timer   <= TW'(DIV - 1);
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                DATA: begin
                    if (expire) begin
                        shift <= {rxd_s, shift[DATA_BITS-1:1]};
                        timer <= TW'(DIV - 1);
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                STOP: begin
                    if (expire) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO only loses the byte when the consumer is not popping the same cycle.
    assign drop = push && fifo_full && !rx.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (i_clr_err) begin
            overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (rx.i_ready),
        .wdata (push_data),
        .rdata (rx.o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rx.o_valid = !fifo_empty;
    assign rx.o_count = count;
    assign o_overrun  = overrun;

endmodule
